// File: rtl/system_control_n_if.sv
// Handshake bundle between the CNN-engine control center and its host/consumers.
// The slave modport is the controller's view; master is the host/consumer side.
interface system_control_n_if #(
  parameter int NUM_CH = 7,
  parameter int ITER_W = 8
);
  logic              start_valid;
  logic              start_ready;
  logic [ITER_W-1:0] start_iters;
  logic [NUM_CH-1:0] start_mask;
  logic [NUM_CH-1:0] init_valid;
  logic [NUM_CH-1:0] init_ready;
  logic [NUM_CH-1:0] fin_valid;
  logic [NUM_CH-1:0] fin_ready;
  logic              done_valid;
  logic              done_ready;
  logic              done_timeout;
  logic              busy;
  logic [ITER_W-1:0] round;

  modport slave (
    input  start_valid, start_iters, start_mask, init_ready, fin_valid, done_ready,
    output start_ready, init_valid, fin_ready, done_valid, done_timeout, busy, round
  );

  modport master (
    output start_valid, start_iters, start_mask, init_ready, fin_valid, done_ready,
    input  start_ready, init_valid, fin_ready, done_valid, done_timeout, busy, round
  );
endinterface

// File: rtl/system_control_n.sv
// Multi-round control center: broadcasts init tokens to enabled channels, gathers
// finish tokens, repeats for the programmed round count, then reports done.
module system_control_n #(
  parameter int NUM_CH  = 7,
  parameter int ITER_W  = 8,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  system_control_n_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BCAST,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [TO_W:0] TO_LIM = (TO_W + 1)'(TIMEOUT);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] acked_q, acked_d;
  logic [NUM_CH-1:0] fin_q, fin_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [ITER_W-1:0] round_q, round_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              tmo_q, tmo_d;

  logic [NUM_CH-1:0] init_vec, fin_rdy_vec;
  logic [NUM_CH-1:0] init_hs, fin_hs;
  logic [TO_W-1:0]   wd_inc;
  logic              wd_hit;
  logic [ITER_W:0]   round_nxt;
  logic              more_rounds;

  // Token outputs are pure decodes of registered state, never of inputs.
  assign init_vec    = (state_q == S_BCAST) ? (mask_q & ~acked_q) : '0;
  assign fin_rdy_vec = (state_q == S_WAIT)  ? (mask_q & ~fin_q)   : '0;
  assign init_hs     = init_vec & bus.init_ready;
  assign fin_hs      = fin_rdy_vec & bus.fin_valid;

  assign wd_inc      = (wd_q == '1) ? wd_q : wd_q + TO_W'(1);
  assign wd_hit      = (TIMEOUT != 0) && ({1'b0, wd_inc} >= TO_LIM);
  assign round_nxt   = {1'b0, round_q} + (ITER_W + 1)'(1);
  assign more_rounds = round_nxt < {1'b0, iters_q};

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    acked_d = acked_q;
    fin_d   = fin_q;
    iters_d = iters_q;
    round_d = round_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_valid) begin
          mask_d  = bus.start_mask;
          iters_d = bus.start_iters;
          round_d = '0;
          wd_d    = '0;
          tmo_d   = 1'b0;
          acked_d = '0;
          fin_d   = '0;
          state_d = (bus.start_iters == '0 || bus.start_mask == '0) ? S_DONE : S_BCAST;
        end
      end

      S_BCAST: begin
        acked_d = acked_q | init_hs;
        wd_d    = wd_inc;
        if (&(acked_d | ~mask_q)) begin
          state_d = S_WAIT;
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_WAIT: begin
        fin_d = fin_q | fin_hs;
        wd_d  = wd_inc;
        // Round completion is tested before the watchdog so a same-cycle tie completes cleanly.
        if (&(fin_d | ~mask_q)) begin
          if (more_rounds) begin
            round_d = round_nxt[ITER_W-1:0];
            acked_d = '0;
            fin_d   = '0;
            wd_d    = '0;
            state_d = S_BCAST;
          end else begin
            state_d = S_DONE;
          end
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.done_ready) begin
          tmo_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      acked_q <= '0;
      fin_q   <= '0;
      iters_q <= '0;
      round_q <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      acked_q <= acked_d;
      fin_q   <= fin_d;
      iters_q <= iters_d;
      round_q <= round_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.start_ready  = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done_valid   = (state_q == S_DONE);
  assign bus.done_timeout = tmo_q;
  assign bus.round        = round_q;
  assign bus.init_valid   = init_vec;
  assign bus.fin_ready    = fin_rdy_vec;

endmodule

// File: tb/tb_system_control_n.sv
// Directed self-checking bench for system_control_n: latency, masking, multi-round,
// watchdog abort, completion/timeout tie, done back-pressure and mid-run reset.
module tb_system_control_n;
  localparam int NUM_CH  = 7;
  localparam int ITER_W  = 8;
  localparam int TO_W    = 16;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  system_control_n_if #(.NUM_CH(NUM_CH), .ITER_W(ITER_W)) bus ();

  system_control_n #(
    .NUM_CH (NUM_CH),
    .ITER_W (ITER_W),
    .TO_W   (TO_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int   ic [NUM_CH];
  int   fc [NUM_CH];
  int   iw [NUM_CH];
  int   fw [NUM_CH];
  logic pend [NUM_CH];
  int   rounds_seen;
  int   bad;
  int   other_i, other_f;
  logic got_done;
  logic [NUM_CH-1:0] m2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_valid = 1'b0;
    bus.start_iters = '0;
    bus.start_mask  = '0;
    bus.init_ready  = '0;
    bus.fin_valid   = '0;
    bus.done_ready  = 1'b0;
  endtask

  function automatic int dly(input int a, input int b);
    return (a * 5 + b * 3 + 1) % 6;
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
    chk("rst_busy",        32'(bus.busy),        32'd0);
    chk("rst_done_valid",  32'(bus.done_valid),  32'd0);
    chk("rst_init_valid",  32'(bus.init_valid),  32'd0);
    chk("rst_fin_ready",   32'(bus.fin_ready),   32'd0);
    chk("rst_round",       32'(bus.round),       32'd0);

    // Minimum latency: start c0, init c1, fin c2, done c3
    bus.init_ready  = '1;
    bus.fin_valid   = '1;
    bus.start_iters = 8'd1;
    bus.start_mask  = 7'h7F;
    bus.start_valid = 1'b1;
    step();
    bus.start_valid = 1'b0;
    chk("t1_init_c1",  32'(bus.init_valid), 32'h7F);
    chk("t1_busy_c1",  32'(bus.busy),       32'd1);
    chk("t1_finr_c1",  32'(bus.fin_ready),  32'd0);
    chk("t1_sready_c1",32'(bus.start_ready),32'd0);
    step();
    chk("t1_finr_c2",  32'(bus.fin_ready),  32'h7F);
    chk("t1_init_c2",  32'(bus.init_valid), 32'd0);
    chk("t1_done_c2",  32'(bus.done_valid), 32'd0);
    step();
    chk("t1_done_c3",  32'(bus.done_valid),  32'd1);
    chk("t1_tmo_c3",   32'(bus.done_timeout),32'd0);
    chk("t1_busy_c3",  32'(bus.busy),        32'd1);
    bus.done_ready = 1'b1;
    step();
    chk("t1_done_c4",  32'(bus.done_valid), 32'd0);
    chk("t1_sready_c4",32'(bus.start_ready),32'd1);
    chk("t1_busy_c4",  32'(bus.busy),       32'd0);
    idle_inputs();

    // Masked multi-round with scrambled stalls; unmasked channels always willing
    m2 = 7'b0000101;
    bus.start_iters = 8'd3;
    bus.start_mask  = m2;
    bus.start_valid = 1'b1;
    step();
    bus.start_valid = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      ic[c] = 0; fc[c] = 0; iw[c] = 0; fw[c] = 0; pend[c] = 1'b0;
    end
    rounds_seen = 0;
    got_done = 1'b0;
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      if (bus.done_valid) begin
        got_done = 1'b1;
      end else begin
        if (bus.busy) rounds_seen |= 1 << int'(bus.round);
        for (int c = 0; c < NUM_CH; c++) begin
          if (m2[c]) begin
            bus.init_ready[c] = bus.init_valid[c] && (iw[c] >= dly(ic[c], c));
            if (bus.init_valid[c] && !bus.init_ready[c]) iw[c]++;
            bus.fin_valid[c] = pend[c] && (fw[c] >= dly(fc[c] + 1, c + 3));
            if (pend[c] && !bus.fin_valid[c]) fw[c]++;
          end else begin
            bus.init_ready[c] = 1'b1;
            bus.fin_valid[c]  = 1'b1;
          end
          if (bus.init_valid[c] && bus.init_ready[c]) begin
            ic[c]++; iw[c] = 0; pend[c] = 1'b1;
          end
          if (bus.fin_valid[c] && bus.fin_ready[c]) begin
            fc[c]++; fw[c] = 0; pend[c] = 1'b0;
          end
        end
        step();
      end
    end
    other_i = 0;
    other_f = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!m2[c]) begin
        other_i += ic[c];
        other_f += fc[c];
      end
    end
    chk("t2_done_seen",  32'(got_done),       32'd1);
    chk("t2_init_ch0",   32'(ic[0]),          32'd3);
    chk("t2_init_ch2",   32'(ic[2]),          32'd3);
    chk("t2_init_other", 32'(other_i),        32'd0);
    chk("t2_fin_ch0",    32'(fc[0]),          32'd3);
    chk("t2_fin_ch2",    32'(fc[2]),          32'd3);
    chk("t2_fin_other",  32'(other_f),        32'd0);
    chk("t2_rounds",     32'(rounds_seen),    32'h7);
    chk("t2_round_done", 32'(bus.round),      32'd2);
    chk("t2_tmo",        32'(bus.done_timeout), 32'd0);
    bus.done_ready = 1'b1;
    step();
    chk("t2_idle", 32'(bus.start_ready), 32'd1);
    idle_inputs();

    // iters == 0 goes straight to done
    bus.init_ready  = '1;
    bus.start_iters = 8'd0;
    bus.start_mask  = 7'h7F;
    bus.start_valid = 1'b1;
    step();
    bus.start_valid = 1'b0;
    chk("t3a_done", 32'(bus.done_valid),   32'd1);
    chk("t3a_init", 32'(bus.init_valid),   32'd0);
    chk("t3a_tmo",  32'(bus.done_timeout), 32'd0);
    bus.done_ready = 1'b1;
    step();
    bus.done_ready = 1'b0;
    chk("t3a_idle", 32'(bus.start_ready), 32'd1);

    // mask == 0 goes straight to done
    bus.start_iters = 8'd5;
    bus.start_mask  = 7'h00;
    bus.start_valid = 1'b1;
    step();
    bus.start_valid = 1'b0;
    chk("t3b_done", 32'(bus.done_valid), 32'd1);
    chk("t3b_init", 32'(bus.init_valid), 32'd0);
    bus.done_ready = 1'b1;
    step();
    chk("t3b_idle", 32'(bus.start_ready), 32'd1);
    idle_inputs();

    // Watchdog: ch3 never finishes -> done at round entry + 20
    bus.init_ready  = '1;
    bus.fin_valid   = 7'b1110111;
    bus.start_iters = 8'd1;
    bus.start_mask  = 7'h7F;
    bus.start_valid = 1'b1;
    step();
    bus.start_valid = 1'b0;
    bad = 0;
    for (int k = 1; k < 20; k++) begin
      if (bus.done_valid) bad++;
      step();
    end
    chk("t4_early_done", 32'(bad),            32'd0);
    chk("t4_done_c20",   32'(bus.done_valid), 32'd0);
    chk("t4_finr_c20",   32'(bus.fin_ready),  32'h08);
    step();
    chk("t4_done_c21",   32'(bus.done_valid),   32'd1);
    chk("t4_tmo_c21",    32'(bus.done_timeout), 32'd1);
    chk("t4_finr_c21",   32'(bus.fin_ready),    32'd0);
    bus.done_ready = 1'b1;
    step();
    chk("t4_tmo_clr",    32'(bus.done_timeout), 32'd0);
    chk("t4_done_clr",   32'(bus.done_valid),   32'd0);
    idle_inputs();

    // Last finish on the watchdog cycle: completion wins; then done back-pressure
    bus.init_ready  = '1;
    bus.fin_valid   = 7'b1110111;
    bus.start_iters = 8'd1;
    bus.start_mask  = 7'h7F;
    bus.start_valid = 1'b1;
    step();
    bus.start_valid = 1'b0;
    for (int k = 1; k < 20; k++) step();
    bus.fin_valid = '1;
    chk("t5_finr_c20", 32'(bus.fin_ready), 32'h08);
    step();
    bus.fin_valid = '0;
    chk("t5_done_c21", 32'(bus.done_valid),   32'd1);
    chk("t5_tmo_c21",  32'(bus.done_timeout), 32'd0);
    chk("t5_round",    32'(bus.round),        32'd0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      bus.start_valid = (k % 2 == 0);
      step();
      if (!bus.done_valid || bus.start_ready || bus.init_valid != '0 || bus.done_timeout)
        bad++;
    end
    bus.start_valid = 1'b0;
    chk("t5_hold", 32'(bad), 32'd0);
    bus.done_ready = 1'b1;
    step();
    bus.done_ready = 1'b0;
    chk("t5_idle_sready", 32'(bus.start_ready), 32'd1);
    chk("t5_idle_busy",   32'(bus.busy),        32'd0);
    step();
    chk("t5_stay_idle",   32'(bus.busy),        32'd0);
    idle_inputs();

    // Reset in round 1 WAIT, then a clean restart
    bus.init_ready  = '1;
    bus.start_iters = 8'd3;
    bus.start_mask  = 7'b0000011;
    bus.start_valid = 1'b1;
    step();
    bus.start_valid = 1'b0;
    step();
    bus.fin_valid = 7'b0000011;
    step();
    bus.fin_valid = '0;
    chk("t6_round_bcast", 32'(bus.round), 32'd1);
    step();
    chk("t6_round_wait",  32'(bus.round),     32'd1);
    chk("t6_finr_wait",   32'(bus.fin_ready), 32'h03);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_sready", 32'(bus.start_ready),  32'd1);
    chk("t6_rst_busy",   32'(bus.busy),         32'd0);
    chk("t6_rst_init",   32'(bus.init_valid),   32'd0);
    chk("t6_rst_finr",   32'(bus.fin_ready),    32'd0);
    chk("t6_rst_done",   32'(bus.done_valid),   32'd0);
    chk("t6_rst_tmo",    32'(bus.done_timeout), 32'd0);
    chk("t6_rst_round",  32'(bus.round),        32'd0);
    bus.fin_valid   = '1;
    bus.start_iters = 8'd1;
    bus.start_mask  = 7'h7F;
    bus.start_valid = 1'b1;
    step();
    bus.start_valid = 1'b0;
    chk("t6_re_init",  32'(bus.init_valid), 32'h7F);
    chk("t6_re_round", 32'(bus.round),      32'd0);
    step();
    step();
    chk("t6_re_done",  32'(bus.done_valid),   32'd1);
    chk("t6_re_tmo",   32'(bus.done_timeout), 32'd0);
    bus.done_ready = 1'b1;
    step();
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/system_control_n.md
Name: system_control_n

Overview:
- Clocked, parametrised successor to the single-shot CSP control center.
- Accepts a start command and broadcasts an init token to NUM_CH enabled consumers (PEs, adder, memory).
- Collects a finish token from every enabled consumer, repeats this for a programmable number of rounds, then reports done.
- Adds a channel-enable mask, multi-round (layer) sequencing and a watchdog timeout. Sits at the top of the NoC CNN engine between the testbench/host and the PE array.

Parameters:
NUM_CH, 7, number of controlled consumer channels (>=1)
ITER_W, 8, width of round count
TO_W, 16, width of watchdog counter
TIMEOUT, 1000, max cycles per round before abort; 0 disables watchdog

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start_valid  in  1  start request
start_ready  out  1  high only in IDLE
start_iters  in  ITER_W  rounds to run, sampled on start handshake
start_mask  in  NUM_CH  channel enables, sampled on start handshake
init_valid  out  NUM_CH  per-channel init token
init_ready  in  NUM_CH  per-channel init accept
fin_valid  in  NUM_CH  per-channel finish token
fin_ready  out  NUM_CH  per-channel finish accept
done_valid  out  1  completion token
done_ready  in  1  completion accept
done_timeout  out  1  qualifies done: 1 = round aborted by watchdog
busy  out  1  high in any state but IDLE
round  out  ITER_W  current round index, 0-based

Behaviour:
- One clock, synchronous active-high reset. A transfer occurs on any valid&&ready at a rising edge.
- Reset (including mid-operation): state=IDLE, all outputs 0 except start_ready=1, latched mask/iters/pending vectors cleared. Tokens in flight are dropped.
- FSM states: IDLE, BCAST, WAIT, DONE.
- IDLE:
  - start_ready=1.
  - On start handshake, latch mask and iters, round=0, clear watchdog.
  - If iters==0 or mask==0, go to DONE with done_timeout=0.
  - Otherwise go to BCAST. init_valid first asserts the cycle after the handshake.
- BCAST:
  - init_valid[i] = mask[i] && !acked[i].
  - acked[i] sets on handshake. init_valid[i] drops the next cycle and is never reasserted in the same round.
  - Channels may accept in any order or simultaneously.
  - fin_ready=0.
  - When all masked channels are acked (including the same-edge last ack), go to WAIT.
- WAIT:
  - fin_ready[i] = mask[i] && !finished[i].
  - finished[i] sets on handshake.
  - When all masked channels are finished:
    - If round+1 < iters: round increments, acked/finished clear, watchdog clears, go to BCAST.
    - Else go to DONE.
  - fin_valid on an unmasked or already-finished channel is ignored (ready stays 0).
- Watchdog:
  - Counts cycles spent in BCAST+WAIT within the current round and saturates at 2^TO_W-1.
  - If TIMEOUT!=0 and count reaches TIMEOUT before the round completes, go to DONE with done_timeout=1. All init_valid/fin_ready drop the same edge.
  - If completion and timeout occur on the same cycle, completion wins (done_timeout=0).
- DONE:
  - done_valid=1, done_timeout stable, round held.
  - On done handshake go to IDLE; done_valid and done_timeout clear.
  - start_valid is ignored outside IDLE.
- Round counter is ITER_W wide. iters=2^ITER_W-1 must run exactly that many rounds with no wrap.
- Minimum latency, iters=1, all ready tied high:
  - start at cycle 0, init at 1, fin accepted at 2, done_valid at 3.
- No combinational path from any input to start_ready or done_valid. init_valid and fin_ready are registered-state decodes.

Test Plan:
- Single round, all NUM_CH=7 enabled, ready/valid tied high, iters=1 -> init at cycle 1, fin at 2, done_valid at 3, done_timeout=0, busy 1..3.
- mask=7'b0000101, iters=3, channels accept init and finish with random 0-5 cycle stalls in scrambled order -> exactly 3 init tokens on ch0 and ch2, none on others; round reads 0,1,2; one done.
- iters=0 and, separately, mask=0 -> done_valid the cycle after start, no init_valid ever asserted.
- TIMEOUT=20, ch3 never raises fin_valid -> done_valid with done_timeout=1 exactly 20 cycles after round entry; fin_ready cleared on that edge.
- Last fin handshake on the same cycle the watchdog hits TIMEOUT -> done_timeout=0. done_ready held low 10 cycles -> done_valid held, and start_valid pulses in that window are ignored.
- Reset asserted mid-WAIT in round 1 -> next cycle all outputs 0, start_ready=1; a new start then runs cleanly from round 0.
